// File: rtl/fp16_normalize_round_if.sv
// Handshake bundle between the adder core and the normalise/round stage.
interface fp16_normalize_round_if #(
  parameter int unsigned EXP_W  = 5,
  parameter int unsigned FRAC_W = 10
);
  logic                    in_valid;
  logic                    in_ready;
  logic [FRAC_W+4:0]       mant_in;
  logic [EXP_W-1:0]        exp_in;
  logic                    sign_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [EXP_W+FRAC_W:0]   result;
  logic                    overflow;
  logic                    underflow;

  // Upstream/downstream side (drives operands, consumes results)
  modport master (
    output in_valid, mant_in, exp_in, sign_in, out_ready,
    input  in_ready, out_valid, result, overflow, underflow
  );

  // Normalise/round block side
  modport slave (
    input  in_valid, mant_in, exp_in, sign_in, out_ready,
    output in_ready, out_valid, result, overflow, underflow
  );
endinterface

// File: rtl/fp16_normalize_round.sv
// Post-addition normalise (1 bit/cycle), round-to-nearest-even and pack stage
// of the half-precision FP adder. One operation in flight.
module fp16_normalize_round #(
  parameter int unsigned EXP_W  = 5,
  parameter int unsigned FRAC_W = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fp16_normalize_round_if.slave bus
);
  localparam int unsigned M_W = FRAC_W + 5;      // carry, hidden, fraction, g/r/s
  localparam int unsigned E_W = EXP_W + 1;       // one spare bit for carry-out
  localparam int unsigned R_W = EXP_W + FRAC_W;  // packed magnitude width

  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_NORM  = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [M_W-1:0]   m_q, m_d;
  logic [E_W-1:0]   e_q, e_d;
  logic             s_q, s_d;
  logic             zero_q, zero_d;
  logic [R_W:0]     result_q, result_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             out_valid_q, out_valid_d;

  logic [EXP_W-1:0] field_c;
  logic             lsb_c, g_c, r_c, st_c, inc_c;
  logic [R_W-1:0]   sum_c;
  logic [EXP_W-1:0] f_exp_c;
  logic [FRAC_W-1:0] f_frac_c;

  // Ready only while idle and out of reset
  assign bus.in_ready  = (state_q == S_IDLE) & rst_n;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

  // Round-to-nearest-even; the fraction carry ripples into the exponent field
  always_comb begin
    field_c  = m_q[M_W-2] ? e_q[EXP_W-1:0] : '0;
    lsb_c    = m_q[3];
    g_c      = m_q[2];
    r_c      = m_q[1];
    st_c     = m_q[0];
    inc_c    = g_c & (r_c | st_c | lsb_c);
    sum_c    = {field_c, m_q[M_W-3:3]} + R_W'(inc_c);
    f_exp_c  = sum_c[R_W-1:FRAC_W];
    f_frac_c = sum_c[FRAC_W-1:0];
  end

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    e_d         = e_q;
    s_d         = s_q;
    zero_d      = zero_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          m_d     = bus.mant_in;
          e_d     = (bus.exp_in == '0) ? E_W'(1) : E_W'(bus.exp_in);
          s_d     = bus.sign_in;
          zero_d  = 1'b0;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (m_q == '0) begin
          // exact cancellation yields +0
          s_d     = 1'b0;
          zero_d  = 1'b1;
          state_d = S_ROUND;
        end else if (m_q[M_W-1]) begin
          // carry out: shift right once, folding the dropped bit into sticky
          m_d     = {1'b0, m_q[M_W-1:2], m_q[1] | m_q[0]};
          e_d     = e_q + E_W'(1);
          state_d = S_ROUND;
        end else if (m_q[M_W-2]) begin
          state_d = S_ROUND;
        end else if (e_q <= E_W'(1)) begin
          state_d = S_ROUND;
        end else begin
          m_d     = m_q << 1;
          e_d     = e_q - E_W'(1);
        end
      end
      S_ROUND: begin
        if (zero_q) begin
          result_d    = '0;
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
        end else begin
          if ((e_q >= E_W'(EXP_MAX)) || (f_exp_c == EXP_MAX)) begin
            result_d   = {s_q, EXP_MAX, FRAC_W'(0)};
            overflow_d = 1'b1;
          end else begin
            result_d   = {s_q, f_exp_c, f_frac_c};
            overflow_d = 1'b0;
          end
          underflow_d = (f_exp_c == '0) & (g_c | r_c | st_c);
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      m_q         <= '0;
      e_q         <= '0;
      s_q         <= 1'b0;
      zero_q      <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      e_q         <= e_d;
      s_q         <= s_d;
      zero_q      <= zero_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_fp16_normalize_round.sv
// Directed bench for fp16_normalize_round: hand-computed vectors, latency,
// backpressure and mid-operation reset.
module tb_fp16_normalize_round;
  logic clk;
  logic rst_n;
  int   vectors;
  int   errors;

  fp16_normalize_round_if bus ();

  fp16_normalize_round dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Issue one operation, wait for out_valid, check outputs and latency, then drain
  task automatic run_op(input string tag, input logic [14:0] mant, input logic [4:0] expo,
                        input logic sgn, input logic [15:0] exp_res, input logic exp_ov,
                        input logic exp_uf, input int exp_lat);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.mant_in  = mant;
    bus.exp_in   = expo;
    bus.sign_in  = sgn;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"},   32'(lat),           32'(exp_lat));
    check({tag, "_result"},    32'(bus.result),    32'(exp_res));
    check({tag, "_overflow"},  32'(bus.overflow),  32'(exp_ov));
    check({tag, "_underflow"}, 32'(bus.underflow), 32'(exp_uf));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic seen_valid;
    vectors = 0;
    errors  = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.mant_in   = '0;
    bus.exp_in    = '0;
    bus.sign_in   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result",    32'(bus.result),    32'd0);
    check("rst_overflow",  32'(bus.overflow),  32'd0);
    check("rst_underflow", 32'(bus.underflow), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Main function and boundaries
    run_op("one_plus_one", 15'h4000, 5'd15, 1'b0, 16'h4000, 1'b0, 1'b0, 3);
    run_op("exact_cancel", 15'h0000, 5'd15, 1'b1, 16'h0000, 1'b0, 1'b0, 3);
    run_op("deep_norm",    15'h0008, 5'd15, 1'b0, 16'h1400, 1'b0, 1'b0, 13);
    run_op("rne_carry",    15'h3FFC, 5'd15, 1'b0, 16'h4000, 1'b0, 1'b0, 3);
    run_op("rne_tie_even", 15'h2004, 5'd15, 1'b0, 16'h3C00, 1'b0, 1'b0, 3);
    run_op("overflow",     15'h4000, 5'd30, 1'b1, 16'hFC00, 1'b1, 1'b0, 3);
    run_op("round_to_inf", 15'h3FFC, 5'd30, 1'b0, 16'h7C00, 1'b1, 1'b0, 3);
    run_op("exp31_input",  15'h2000, 5'd31, 1'b0, 16'h7C00, 1'b1, 1'b0, 3);
    run_op("exp0_as_1",    15'h1000, 5'd0,  1'b0, 16'h0200, 1'b0, 1'b0, 3);
    run_op("denorm_to_norm", 15'h1FFC, 5'd1, 1'b1, 16'h8400, 1'b0, 1'b0, 3);

    // Denormal result held under backpressure; in_valid meanwhile is ignored
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.mant_in  = 15'h1001;
    bus.exp_in   = 5'd1;
    bus.sign_in  = 1'b0;
    @(posedge clk); #1;
    bus.mant_in  = 15'h4000;
    bus.exp_in   = 5'd20;
    repeat (3) @(posedge clk);
    #1;
    check("bp_valid",     32'(bus.out_valid), 32'd1);
    check("bp_result",    32'(bus.result),    32'h0200);
    check("bp_underflow", 32'(bus.underflow), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid",  32'(bus.out_valid), 32'd1);
      check("bp_hold_result", 32'(bus.result),    32'h0200);
      check("bp_in_ready",    32'(bus.in_ready),  32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_released", 32'(bus.out_valid), 32'd0);
    check("bp_idle",     32'(bus.in_ready),  32'd1);

    // Reset during NORM aborts the operation
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.mant_in  = 15'h0008;
    bus.exp_in   = 5'd15;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_in_ready", 32'(bus.in_ready),  32'd0);
    check("mid_rst_result",   32'(bus.result),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen_valid = 1'b1;
    end
    check("mid_rst_no_valid", 32'(seen_valid),   32'd0);
    check("mid_rst_idle",     32'(bus.in_ready), 32'd1);

    // Operation after the aborted one still works
    run_op("post_reset", 15'h4000, 5'd15, 1'b1, 16'hC000, 1'b0, 1'b0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
